// File: rtl/mdu_ctrl_pkg.sv
// Shared MIPS core codes: datapath width, SPECIAL funct field values and
// the multiply/divide sequencer state type.
package codes;

    typedef logic [31:0] size_t;
    typedef logic [5:0]  func_t;

    localparam func_t FUNC_SLL   = 6'h00;
    localparam func_t FUNC_MFHI  = 6'h10;
    localparam func_t FUNC_MTHI  = 6'h11;
    localparam func_t FUNC_MFLO  = 6'h12;
    localparam func_t FUNC_MTLO  = 6'h13;
    localparam func_t FUNC_MULT  = 6'h18;
    localparam func_t FUNC_MULTU = 6'h19;
    localparam func_t FUNC_DIV   = 6'h1A;
    localparam func_t FUNC_DIVU  = 6'h1B;
    localparam func_t FUNC_ADD   = 6'h20;
    localparam func_t FUNC_SUB   = 6'h22;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUL   = 2'd1,
        DIV   = 2'd2,
        FIXUP = 2'd3
    } mdu_state_t;

    localparam int MDU_ITERATIONS = 32;

endpackage

// File: rtl/mdu_ctrl_if.sv
// CPU <-> multiply/divide unit signal bundle; the CPU side is the master.
interface mdu_ctrl_if;
    import codes::*;

    logic  start_i;
    func_t funct_i;
    size_t rs_i;
    size_t rt_i;
    logic  mf_read_i;
    logic  stall_o;
    logic  busy_o;
    logic  done_o;
    size_t hi_o;
    size_t lo_o;

    modport master (
        output start_i, funct_i, rs_i, rt_i, mf_read_i,
        input  stall_o, busy_o, done_o, hi_o, lo_o
    );

    modport slave (
        input  start_i, funct_i, rs_i, rt_i, mf_read_i,
        output stall_o, busy_o, done_o, hi_o, lo_o
    );

endinterface

// File: rtl/mdu_shift_core.sv
// Per-iteration datapath: unsigned 64-bit shift-add multiply or restoring
// divide on magnitudes; sign handling lives in the controller.
module mdu_shift_core
    import codes::*;
(
    input  logic  clk,
    input  logic  i_load,
    input  logic  i_div,
    input  logic  i_step,
    input  size_t i_a,
    input  size_t i_b,
    output size_t o_hi,
    output size_t o_lo
);

    size_t       r_hi;
    size_t       r_lo;
    size_t       r_opb;
    logic        r_div;

    logic [32:0] w_sum;
    logic [32:0] w_shift;
    size_t       w_diff;
    logic        w_ge;

    // Multiply: LO holds the multiplier; divide: LO holds the dividend and
    // collects quotient bits while HI is the partial remainder.
    always_comb begin
        w_sum   = {1'b0, r_hi} + {1'b0, r_opb};
        w_shift = {r_hi, r_lo[31]};
        w_ge    = (w_shift >= {1'b0, r_opb});
        w_diff  = w_shift[31:0] - r_opb;
    end

    always_ff @(posedge clk) begin
        if (i_load) begin
            r_div <= i_div;
            r_opb <= i_div ? i_b : i_a;
            r_hi  <= '0;
            r_lo  <= i_div ? i_a : i_b;
        end else if (i_step) begin
            if (r_div) begin
                if (w_ge) {r_hi, r_lo} <= {w_diff, r_lo[30:0], 1'b1};
                else      {r_hi, r_lo} <= {w_shift[31:0], r_lo[30:0], 1'b0};
            end else begin
                if (r_lo[0]) {r_hi, r_lo} <= {w_sum, r_lo[31:1]};
                else         {r_hi, r_lo} <= {1'b0, r_hi, r_lo[31:1]};
            end
        end
    end

    assign o_hi = r_hi;
    assign o_lo = r_lo;

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning the HI/LO pair; stalls
// the CPU on HI/LO access while an operation is in flight.
module mdu_ctrl
    import codes::*;
(
    input  logic       clk,
    input  logic       reset_n_i,
    mdu_ctrl_if.slave  bus
);

    mdu_state_t  r_state;
    mdu_state_t  w_state_nxt;
    logic [4:0]  r_cnt;
    size_t       r_hi;
    size_t       r_lo;
    logic        r_done;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_zero;
    logic        r_is_div;

    logic        w_load;
    logic        w_load_div;
    logic        w_step;
    logic        w_fix;
    logic        w_mt_hi;
    logic        w_mt_lo;
    logic        w_signed;
    size_t       w_core_a;
    size_t       w_core_b;
    size_t       w_core_hi;
    size_t       w_core_lo;
    logic [63:0] w_prod_fix;
    size_t       w_hi_fix;
    size_t       w_lo_fix;

    function automatic size_t f_abs(input logic signed [31:0] v);
        return v[31] ? size_t'(-v) : size_t'(v);
    endfunction

    function automatic size_t f_neg32(input size_t v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [63:0] f_neg64(input logic [63:0] v, input logic neg);
        return neg ? (~v + 64'd1) : v;
    endfunction

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) r_state <= IDLE;
        else            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_load_div  = 1'b0;
        w_step      = 1'b0;
        w_fix       = 1'b0;
        w_mt_hi     = 1'b0;
        w_mt_lo     = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start_i) begin
                    case (bus.funct_i)
                        FUNC_MULT, FUNC_MULTU: begin
                            w_load      = 1'b1;
                            w_state_nxt = MUL;
                        end
                        FUNC_DIV, FUNC_DIVU: begin
                            w_load      = 1'b1;
                            w_load_div  = 1'b1;
                            w_state_nxt = (bus.rt_i == '0) ? FIXUP : DIV;
                        end
                        FUNC_MTHI: w_mt_hi = 1'b1;
                        FUNC_MTLO: w_mt_lo = 1'b1;
                        default:   ;
                    endcase
                end
            end
            MUL, DIV: begin
                w_step = 1'b1;
                if (r_cnt == 5'(MDU_ITERATIONS - 1)) w_state_nxt = FIXUP;
            end
            FIXUP: begin
                w_fix       = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Iteration 31 leaves the counter wrapped to 0, ready for the next op.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i)  r_cnt <= '0;
        else if (w_load) r_cnt <= '0;
        else if (w_step) r_cnt <= r_cnt + 5'd1;
    end

    assign w_signed = (bus.funct_i == FUNC_MULT) || (bus.funct_i == FUNC_DIV);
    assign w_core_a = w_signed ? f_abs(bus.rs_i) : bus.rs_i;
    assign w_core_b = w_signed ? f_abs(bus.rt_i) : bus.rt_i;

    always_ff @(posedge clk) begin
        if (w_load) begin
            r_neg_q  <= w_signed & (bus.rs_i[31] ^ bus.rt_i[31]);
            r_neg_r  <= w_signed & bus.rs_i[31];
            r_zero   <= w_load_div & (bus.rt_i == '0);
            r_is_div <= w_load_div;
        end
    end

    mdu_shift_core u_core (
        .clk    (clk),
        .i_load (w_load),
        .i_div  (w_load_div),
        .i_step (w_step),
        .i_a    (w_core_a),
        .i_b    (w_core_b),
        .o_hi   (w_core_hi),
        .o_lo   (w_core_lo)
    );

    // Remainder follows the dividend sign, so 0x80000000 / -1 needs no trap.
    always_comb begin
        w_prod_fix = f_neg64({w_core_hi, w_core_lo}, r_neg_q);
        w_hi_fix   = w_prod_fix[63:32];
        w_lo_fix   = w_prod_fix[31:0];
        if (r_zero) begin
            w_hi_fix = '0;
            w_lo_fix = '0;
        end else if (r_is_div) begin
            w_hi_fix = f_neg32(w_core_hi, r_neg_r);
            w_lo_fix = f_neg32(w_core_lo, r_neg_q);
        end
    end

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_hi   <= '0;
            r_lo   <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_fix;
            if (w_fix) begin
                r_hi <= w_hi_fix;
                r_lo <= w_lo_fix;
            end else begin
                if (w_mt_hi) r_hi <= bus.rs_i;
                if (w_mt_lo) r_lo <= bus.rs_i;
            end
        end
    end

    assign bus.busy_o  = (r_state != IDLE);
    assign bus.stall_o = bus.busy_o & (bus.start_i | bus.mf_read_i);
    assign bus.done_o  = r_done;
    assign bus.hi_o    = r_hi;
    assign bus.lo_o    = r_lo;

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multi-cycle multiply/divide controller that owns the HI/LO register pair for the MIPS core. It replaces single-cycle `*`, `/` and `%` with a 32-iteration shift-add / restoring-divide sequencer. It stalls the CPU when HI/LO are read or re-targeted while an operation is still in flight. It sits beside the ALU, is driven from the decoded OP_SPECIAL funct field, and feeds MFHI/MFLO writeback.

## Interface
Parameters:
- none; data width is fixed at 32 by `size_t`.

Ports:
- clk  in  1  Single clock for the whole block.
- reset_n_i  in  1  Asynchronous, active-low reset.
- start_i  in  1  Issue strobe; the instruction is OP_SPECIAL and funct_i is MULT, MULTU, DIV, DIVU, MTHI or MTLO.
- funct_i  in  func_t  Funct field qualifying start_i.
- rs_i  in  size_t  Operand A (dividend / multiplicand / MTHI or MTLO source).
- rt_i  in  size_t  Operand B (divisor / multiplier).
- mf_read_i  in  1  The CPU is executing MFHI or MFLO this cycle.
- stall_o  out  1  Combinational; the CPU must hold its current instruction.
- busy_o  out  1  An operation is in flight (state != IDLE).
- done_o  out  1  One-cycle pulse; new HI/LO values are visible this cycle.
- hi_o  out  size_t  Registered HI.
- lo_o  out  size_t  Registered LO.

## Operation
- States: IDLE, MUL, DIV, FIXUP.
- IDLE + start_i:
  - MULT/MULTU -> MUL.
  - DIV/DIVU with rt_i != 0 -> DIV.
  - DIV/DIVU with rt_i == 0 -> FIXUP directly, with a zero-result flag set.
  - MTHI/MTLO -> write hi_o/lo_o from rs_i at that edge; state stays IDLE; no done_o.
- Operand capture at acceptance:
  - Signed ops latch |rs_i|, |rt_i| and a sign flag per result.
  - Unsigned ops latch the raw values with the flags cleared.
- MUL: 32 iterations of a 64-bit shift-add, using the LSB of the multiplier; a 5-bit counter runs 0..31.
- DIV: 32 iterations of restoring division; 33-bit partial remainder, quotient bit shifted in per cycle.
- Counter wrap 31 -> FIXUP.
- FIXUP (one edge) writes hi_o/lo_o, then returns to IDLE.
- Sign rules in FIXUP:
  - Product: negated (64-bit two's complement) if operand signs differ.
  - Quotient: negated if signs differ.
  - Remainder: takes the sign of the dividend.
- Divide by zero: HI = LO = 0.
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0; no trap.
- stall_o = busy_o & (start_i | mf_read_i).
  - While stalled, start_i is ignored; the CPU re-presents it.
  - MTHI/MTLO issued while busy therefore wait and never corrupt an in-flight result.
- hi_o/lo_o hold their old values throughout MUL/DIV.

## Timing
- Reset, asynchronous: state = IDLE, counter = 0, hi_o = lo_o = 0, busy_o = 0, done_o = 0.
  - Reset mid-operation aborts the operation; no partial result is written.
- Acceptance edge E0. Iterations on E1..E32. FIXUP write on E33.
  - done_o is high, and hi_o/lo_o are valid, in the cycle after E33.
  - busy_o is high for the 33 cycles after E0 and low in the done_o cycle.
- Divide by zero: FIXUP on E1; done_o in the cycle after E1.
- A start_i in the done_o cycle is accepted (state is IDLE); back-to-back issue is legal.
- mf_read_i in the done_o cycle: no stall; the read returns the new values.
- MTHI/MTLO: hi_o/lo_o update on the acceptance edge; 1-cycle latency.
- start_i with a non-MDU funct: ignored, no state change.

## Structure
- Shared package `codes`:
  - Existing `func_t`/FUNC_* and `size_t`.
  - New `mdu_state_t` enum (IDLE, MUL, DIV, FIXUP).
  - Constant MDU_ITERATIONS = 32.
- Sub-module `mdu_shift_core`: the per-iteration 64-bit shift-add / restoring-subtract datapath, with mode, load and step inputs.
- `mdu_ctrl` keeps the FSM, counter, sign flags, fixup and HI/LO registers.
- The ALU's HI/LO logic and mfhi_o/mflo_o are retired in favour of hi_o/lo_o.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> busy_o high for 33 cycles; done_o pulse; HI = 0xFFFFFFFE, LO = 0x00000001.
- MULT -3 × 5 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFF1.
- DIV -7 / 2:
  - -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
  - Then DIVU 7 / 2 issued in the done_o cycle -> LO = 3, HI = 1.
  - Then DIV 0x80000000 / -1 -> LO = 0x80000000, HI = 0.
- DIV 5 / 0 -> done_o in the cycle after E1; HI = LO = 0.
- MFHI and MTLO 0x1234 presented during MUL:
  - -> stall_o = 1 every cycle until the done_o cycle.
  - MTLO is then applied: LO = 0x00001234, HI = product high word.
- reset_n_i pulsed low at iteration 10 of a MULTU:
  - -> busy_o = 0 and HI = LO = 0 immediately.
  - A following MULTU 2 × 3 -> LO = 6, HI = 0.
